// File: rtl/instr_fetch_sequencer.sv
// Instruction-side sequencer for IR_decode: owns the PC, the FETCH/EXEC1/EXEC2 phase ring,
// instruction-memory reads, load-hazard NOP injection, delayed branches and halt-on-zero.
module instr_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic [31:0] current_instruction,
  output logic        is_current_instruction_valid,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  input  logic        memory_hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        active
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC1  = 2'd1;
  localparam logic [1:0] S_EXEC2  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]  state;
  logic        started;
  logic [31:0] pc_q;
  logic [31:0] saved_target;
  logic        branch_pending;
  logic        hazard_pending;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        active_q;
  logic [31:0] next_pc;

  // started keeps every phase strobe low during the first cycle after reset release
  assign fetch  = started && (state == S_FETCH);
  assign exec1  = started && (state == S_EXEC1);
  assign exec2  = started && (state == S_EXEC2);

  assign instr_read                   = fetch && !hazard_pending;
  assign instr_address                = pc_q;
  assign pc                           = pc_q;
  assign current_instruction          = instr_q;
  assign is_current_instruction_valid = valid_q;
  assign active                       = active_q;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (branch_pending) next_pc = saved_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_FETCH;
      started        <= 1'b0;
      pc_q           <= RESET_VECTOR;
      saved_target   <= '0;
      branch_pending <= 1'b0;
      hazard_pending <= 1'b0;
      instr_q        <= '0;
      valid_q        <= 1'b0;
      active_q       <= 1'b1;
    end else begin
      started <= 1'b1;
      if (started) begin
        case (state)
          S_FETCH: begin
            if (hazard_pending) begin
              instr_q        <= '0;
              valid_q        <= 1'b1;
              hazard_pending <= 1'b0;
              state          <= S_EXEC1;
            end else if (!instr_waitrequest) begin
              instr_q <= instr_readdata;
              valid_q <= 1'b1;
              state   <= S_EXEC1;
            end
          end
          S_EXEC1: state <= S_EXEC2;
          S_EXEC2: begin
            // a hazard defers the whole pc/branch update until the NOP round's EXEC2
            if (memory_hazard) begin
              hazard_pending <= 1'b1;
              state          <= S_FETCH;
            end else begin
              branch_pending <= 1'b0;
              if (next_pc == 32'h0) begin
                state    <= S_HALTED;
                active_q <= 1'b0;
                valid_q  <= 1'b0;
              end else begin
                pc_q  <= next_pc;
                state <= S_FETCH;
              end
            end
            // placed last so a branch in the delay slot re-arms the pending redirect
            if (branch_taken) begin
              saved_target   <= branch_target & 32'hFFFF_FFFC;
              branch_pending <= 1'b1;
            end
          end
          default: state <= S_HALTED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomized bench for instr_fetch_sequencer: a round-level program-flow model predicts
// phases, fetch addresses, presented instruction and halt, with random mid-run resets.
module tb_instr_fetch_sequencer;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_readdata;
  logic [31:0] current_instruction;
  logic        is_current_instruction_valid;
  logic        fetch, exec1, exec2;
  logic        memory_hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        active;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .instr_address                (instr_address),
    .instr_read                   (instr_read),
    .instr_waitrequest            (instr_waitrequest),
    .instr_readdata               (instr_readdata),
    .current_instruction          (current_instruction),
    .is_current_instruction_valid (is_current_instruction_valid),
    .fetch                        (fetch),
    .exec1                        (exec1),
    .exec2                        (exec2),
    .memory_hazard                (memory_hazard),
    .branch_taken                 (branch_taken),
    .branch_target                (branch_target),
    .pc                           (pc),
    .active                       (active)
  );

  int unsigned vectors;
  int unsigned miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h01000193) ^ 32'hA5A5_3C3C;
  endfunction

  // Program-flow model: position inside the 3-cycle round, architectural pc,
  // pending delayed-branch target, pending NOP and the instruction on display.
  logic [31:0] m_pc, m_tgt, m_instr, nxt;
  bit          m_pend, m_nop, m_valid, m_halted;
  int          pos;
  int          halt_cycles;

  task automatic model_init();
    m_pc = RV; m_tgt = '0; m_instr = '0;
    m_pend = 0; m_nop = 0; m_valid = 0; m_halted = 0;
    pos = 0; halt_cycles = 0;
  endtask

  task automatic idle_inputs();
    instr_waitrequest = 1'b0;
    instr_readdata    = '0;
    memory_hazard     = 1'b0;
    branch_taken      = 1'b0;
    branch_target     = '0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, then releases it.
  task automatic reset_dut();
    #2 reset_n = 1'b0;
    #1;
    check("rst_read",  {31'b0, instr_read}, 32'd0);
    check("rst_fetch", {29'b0, fetch, exec1, exec2}, 32'd0);
    check("rst_valid", {31'b0, is_current_instruction_valid}, 32'd0);
    check("rst_instr", current_instruction, 32'd0);
    check("rst_pc",    pc, RV);
    check("rst_active", {31'b0, active}, 32'd1);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_phases", {29'b0, fetch, exec1, exec2}, 32'd0);
    check("rel_read",   {31'b0, instr_read}, 32'd0);
    model_init();
    @(posedge clk);
  endtask

  task automatic check_outputs();
    if (m_halted) begin
      check("halt_phases", {29'b0, fetch, exec1, exec2}, 32'd0);
      check("halt_read",   {31'b0, instr_read}, 32'd0);
      check("halt_active", {31'b0, active}, 32'd0);
      check("halt_valid",  {31'b0, is_current_instruction_valid}, 32'd0);
    end else begin
      check("phases", {29'b0, fetch, exec1, exec2},
            {29'b0, pos == 0, pos == 1, pos == 2});
      check("read",   {31'b0, instr_read}, {31'b0, (pos == 0) && !m_nop});
      check("active", {31'b0, active}, 32'd1);
      check("valid",  {31'b0, is_current_instruction_valid}, {31'b0, m_valid});
      check("instr",  current_instruction, m_instr);
      check("pc",     pc, m_pc);
      check("addr",   instr_address, m_pc);
    end
  endtask

  task automatic drive_random();
    instr_waitrequest = ($urandom_range(0, 2) == 0);
    // memory answers whatever address is actually requested
    instr_readdata    = instr_waitrequest ? $urandom : mem_word(instr_address);
    memory_hazard     = ($urandom_range(0, 5) == 0);
    branch_taken      = ($urandom_range(0, 4) == 0);
    case ($urandom_range(0, 15))
      0:       branch_target = 32'h0;
      1:       branch_target = 32'hFFFF_FFF8;
      2, 3:    branch_target = $urandom;
      default: branch_target = RV + ($urandom_range(0, 255) << 2);
    endcase
  endtask

  task automatic model_step();
    case (pos)
      0: begin
        if (m_nop) begin
          m_instr = '0; m_valid = 1; m_nop = 0; pos = 1;
        end else if (!instr_waitrequest) begin
          m_instr = mem_word(m_pc); m_valid = 1; pos = 1;
        end
      end
      1: pos = 2;
      default: begin
        nxt = m_pend ? m_tgt : m_pc + 32'd4;
        if (memory_hazard) m_nop = 1;
        else begin
          m_pend = 0;
          if (nxt == 32'h0) begin m_halted = 1; m_valid = 0; end
          else m_pc = nxt;
        end
        if (branch_taken) begin
          m_tgt  = {branch_target[31:2], 2'b00};
          m_pend = 1;
        end
        pos = 0;
      end
    endcase
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b1;
    idle_inputs();
    model_init();
    reset_dut();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (m_halted) begin
        halt_cycles++;
        if (halt_cycles >= 3) begin
          reset_dut();
          continue;
        end
      end else if ($urandom_range(0, 399) == 0) begin
        reset_dut();
        continue;
      end
      drive_random();
      @(posedge clk);
      if (!m_halted) model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
